mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter READY_TIMEOUT, default 64: the maximum number of cycles in ACCESS without dmem_ready before the access aborts.
REQ-002 SHALL have ports clock in 1 (rising-edge system clock) and reset in 1 (asynchronous, active-high).
REQ-003 SHALL have inputs ex_valid 1, ex_ralu 32 (effective address/ALU result), ex_rs2 32 (store data), ex_npc 32, ex_write_addr 6, ex_i (riscv::inst_type), ex_mem_ce 1, ex_rw 1 (1=load, 0=store), ex_bw 1 and ex_wreg 1; these carry the EX_MEM register contents.
REQ-004 SHALL have output mem_stall 1; while it is high, upstream holds EX_MEM unchanged.
REQ-005 SHALL have outputs dmem_ce 1, dmem_rw 1, dmem_be 4, dmem_addr 32 (word-aligned) and dmem_wdata 32, and inputs dmem_rdata 32 and dmem_ready 1.
REQ-006 SHALL have outputs wb_valid 1, wb_ralu 32, wb_npc 32, wb_read_data 32, wb_write_addr 6, wb_wreg 1 and wb_i (riscv::inst_type); these form the MEM_WB register.
REQ-007 SHALL have outputs misalign 1 and bus_error 1, each a one-cycle error pulse.
REQ-008 SHALL use a single clock domain with asynchronous active-high reset, as already decided.

Function
REQ-009 SHALL implement an FSM with states IDLE and ACCESS, plus a timeout counter of width clog2(READY_TIMEOUT+1).
REQ-010 When in IDLE with ex_valid=0, SHALL load wb_valid=0 at the next edge; all other wb_* outputs hold.
REQ-011 When in IDLE with ex_valid=1 and ex_mem_ce=0, SHALL at the next edge copy ex_* into wb_*, set wb_read_data=0 and wb_valid=1, and keep mem_stall=0, giving 1-cycle latency.
REQ-012 Alignment: LH/LHU/SH SHALL be misaligned when addr[0]=1; LW/SW SHALL be misaligned when addr[1:0]!=0; LB/LBU/SB are never misaligned.
REQ-013 For a misaligned access in IDLE: no dmem_ce, misalign pulses at the next edge, wb_valid=1 with wb_wreg=0, mem_stall=0.
REQ-014 For an aligned access in IDLE: mem_stall=1 combinationally that cycle; at the edge, latch address, data, size and control, then go to ACCESS with counter=0.
REQ-015 In ACCESS: dmem_ce=1, dmem_rw=latched rw, dmem_addr={addr[31:2],2'b00}, mem_stall=1 unless dmem_ready=1; ex_* are ignored.
REQ-016 dmem_be: SB -> 4'b0001<<addr[1:0]; SH -> 4'b0011 (addr[1]=0) or 4'b1100; SW and all loads -> 4'b1111.
REQ-017 dmem_wdata: SB -> the rs2[7:0] byte replicated x4; SH -> rs2[15:0] replicated x2; SW -> rs2.
REQ-018 On ACCESS with dmem_ready=1: mem_stall=0 that cycle; at the edge, write wb_* (wb_read_data formatted), set wb_valid=1, and go to IDLE.
REQ-019 The edge that completes ACCESS SHALL NOT accept the ex_* entry present in that cycle; acceptance resumes in the following IDLE cycle.
REQ-020 Load format: select the byte at addr[1:0] or the half at addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
REQ-021 Stores SHALL force wb_wreg=0 and wb_read_data=0; loads SHALL pass wb_wreg=ex_wreg.
REQ-022 In ACCESS without ready, the counter SHALL increment; when counter==READY_TIMEOUT-1 and dmem_ready=0, at the edge: bus_error pulse, wb_valid=1, wb_wreg=0, go to IDLE.
REQ-023 dmem_ready arriving in IDLE SHALL be ignored.
REQ-024 Minimum load/store latency SHALL be 2 cycles from acceptance (ready on the first ACCESS cycle).

Reset
REQ-025 Reset SHALL asynchronously force IDLE, counter=0, dmem_ce=0, mem_stall=0, wb_valid=0, wb_wreg=0, misalign=0, bus_error=0, and all wb_*, dmem_addr, dmem_wdata and dmem_be to 0.
REQ-026 Reset asserted during ACCESS SHALL drop dmem_ce in the same cycle, with no wb_valid and no error pulse.
REQ-027 After reset deasserts, the first accepted entry SHALL be processed normally.

Verification
REQ-028 ADD, ralu=0x1234, wreg=1, addr 5 -> next cycle wb_valid=1, wb_ralu=0x1234, wb_write_addr=5, mem_stall stays 0.
REQ-029 LB addr 0x103, memory word 0x80FF_FF00, ready after 3 cycles -> dmem_addr=0x100, be=1111, wb_read_data=0xFFFF_FF80; LBU of the same -> 0x0000_0080.
REQ-030 SH addr 0x202, rs2=0xABCD_1234 -> dmem_be=1100, dmem_wdata=0x1234_1234, dmem_rw=0, wb_wreg=0.
REQ-031 LW addr 0x301 -> no dmem_ce, misalign pulse, wb_valid=1 with wb_wreg=0; a following aligned LW proceeds normally.
REQ-032 SW with dmem_ready held 0, READY_TIMEOUT=4 -> 4 ACCESS cycles, then bus_error pulse and return to IDLE.
REQ-033 Reset asserted on the 2nd ACCESS cycle of an LW -> dmem_ce=0 immediately, wb_valid=0, state IDLE after release.

Source files
------------

// File: rtl/mem_stage.sv
// Memory stage of the pipeline: turns the EX_MEM register into a data-memory
// access (IDLE/ACCESS handshake with timeout) and produces the MEM_WB register.
package riscv;
    typedef enum logic [5:0] {
        I_NOP = 6'd0,
        I_ADD,
        I_SUB,
        I_LB,
        I_LH,
        I_LW,
        I_LBU,
        I_LHU,
        I_SB,
        I_SH,
        I_SW
    } inst_type;
endpackage

module mem_stage #(
    parameter int READY_TIMEOUT = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ex_valid,
    input  logic [31:0]      ex_ralu,
    input  logic [31:0]      ex_rs2,
    input  logic [31:0]      ex_npc,
    input  logic [5:0]       ex_write_addr,
    input  riscv::inst_type  ex_i,
    input  logic             ex_mem_ce,
    input  logic             ex_rw,
    input  logic             ex_bw,
    input  logic             ex_wreg,
    output logic             mem_stall,
    output logic             dmem_ce,
    output logic             dmem_rw,
    output logic [3:0]       dmem_be,
    output logic [31:0]      dmem_addr,
    output logic [31:0]      dmem_wdata,
    input  logic [31:0]      dmem_rdata,
    input  logic             dmem_ready,
    output logic             wb_valid,
    output logic [31:0]      wb_ralu,
    output logic [31:0]      wb_npc,
    output logic [31:0]      wb_read_data,
    output logic [5:0]       wb_write_addr,
    output logic             wb_wreg,
    output riscv::inst_type  wb_i,
    output logic             misalign,
    output logic             bus_error
);

    localparam int CNT_W = $clog2(READY_TIMEOUT + 1);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACCESS = 1'b1;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    function automatic logic [1:0] size_of(input riscv::inst_type i);
        case (i)
            riscv::I_LB, riscv::I_LBU, riscv::I_SB: size_of = SZ_B;
            riscv::I_LH, riscv::I_LHU, riscv::I_SH: size_of = SZ_H;
            default:                                size_of = SZ_W;
        endcase
    endfunction

    function automatic logic is_unsigned(input riscv::inst_type i);
        is_unsigned = (i == riscv::I_LBU) || (i == riscv::I_LHU);
    endfunction

    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] a);
        case (sz)
            SZ_B:    is_misaligned = 1'b0;
            SZ_H:    is_misaligned = a[0];
            default: is_misaligned = (a != 2'b00);
        endcase
    endfunction

    // Loads always fetch the whole word; only stores narrow the lane mask.
    function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic load,
                                           input logic [1:0] a);
        if (load) begin
            byte_en = 4'b1111;
        end else begin
            case (sz)
                SZ_B:    byte_en = 4'b0001 << a;
                SZ_H:    byte_en = a[1] ? 4'b1100 : 4'b0011;
                default: byte_en = 4'b1111;
            endcase
        end
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] sz, input logic [31:0] d);
        case (sz)
            SZ_B:    store_data = {4{d[7:0]}};
            SZ_H:    store_data = {2{d[15:0]}};
            default: store_data = d;
        endcase
    endfunction

    function automatic logic [31:0] load_fmt(input logic [1:0] sz, input logic uns,
                                             input logic [1:0] a, input logic [31:0] d);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = d[8*a +: 8];
        h = a[1] ? d[31:16] : d[15:0];
        case (sz)
            SZ_B:    load_fmt = uns ? {24'd0, b} : 32'(b);
            SZ_H:    load_fmt = uns ? {16'd0, h} : 32'(h);
            default: load_fmt = d;
        endcase
    endfunction

    logic [0:0]      state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]     acc_ralu;
    logic [31:0]     acc_npc;
    logic [5:0]      acc_waddr;
    riscv::inst_type acc_i;
    logic            acc_wreg;

    logic [1:0]      ex_size;
    logic            ex_mis;
    logic            accept_mem;
    logic            timeout;

    // The bus-width hint is redundant with the instruction type.
    logic            unused_bw;
    assign unused_bw = ex_bw;

    assign ex_size    = size_of(ex_i);
    assign ex_mis     = is_misaligned(ex_size, ex_ralu[1:0]);
    assign accept_mem = (state == IDLE) && ex_valid && ex_mem_ce && !ex_mis;
    assign timeout    = (cnt == CNT_W'(READY_TIMEOUT - 1));

    assign dmem_ce   = (state == ACCESS);
    assign dmem_addr = {acc_ralu[31:2], 2'b00};
    assign mem_stall = !reset && ((state == IDLE) ? accept_mem : !dmem_ready);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            acc_ralu      <= '0;
            acc_npc       <= '0;
            acc_waddr     <= '0;
            acc_i         <= riscv::I_NOP;
            acc_wreg      <= 1'b0;
            dmem_rw       <= 1'b0;
            dmem_be       <= '0;
            dmem_wdata    <= '0;
            wb_valid      <= 1'b0;
            wb_ralu       <= '0;
            wb_npc        <= '0;
            wb_read_data  <= '0;
            wb_write_addr <= '0;
            wb_wreg       <= 1'b0;
            wb_i          <= riscv::I_NOP;
            misalign      <= 1'b0;
            bus_error     <= 1'b0;
        end else begin
            wb_valid  <= 1'b0;
            misalign  <= 1'b0;
            bus_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (ex_valid && (!ex_mem_ce || ex_mis)) begin
                        // Non-memory op or rejected misaligned access retires directly.
                        wb_valid      <= 1'b1;
                        wb_ralu       <= ex_ralu;
                        wb_npc        <= ex_npc;
                        wb_read_data  <= '0;
                        wb_write_addr <= ex_write_addr;
                        wb_i          <= ex_i;
                        wb_wreg       <= ex_mem_ce ? 1'b0 : ex_wreg;
                        misalign      <= ex_mem_ce;
                    end else if (accept_mem) begin
                        acc_ralu   <= ex_ralu;
                        acc_npc    <= ex_npc;
                        acc_waddr  <= ex_write_addr;
                        acc_i      <= ex_i;
                        acc_wreg   <= ex_wreg;
                        dmem_rw    <= ex_rw;
                        dmem_be    <= byte_en(ex_size, ex_rw, ex_ralu[1:0]);
                        dmem_wdata <= store_data(ex_size, ex_rs2);
                        cnt        <= '0;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (dmem_ready || timeout) begin
                        wb_valid      <= 1'b1;
                        wb_ralu       <= acc_ralu;
                        wb_npc        <= acc_npc;
                        wb_write_addr <= acc_waddr;
                        wb_i          <= acc_i;
                        wb_wreg       <= dmem_ready && dmem_rw && acc_wreg;
                        wb_read_data  <= (dmem_ready && dmem_rw)
                                         ? load_fmt(size_of(acc_i), is_unsigned(acc_i),
                                                    acc_ralu[1:0], dmem_rdata)
                                         : 32'd0;
                        bus_error     <= !dmem_ready;
                        cnt           <= '0;
                        state         <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: table of single-cycle retirements plus
// hand-written load/store, timeout and reset sequences.
module tb_mem_stage;

    logic            clock = 1'b0;
    logic            reset;
    logic            ex_valid;
    logic [31:0]     ex_ralu;
    logic [31:0]     ex_rs2;
    logic [31:0]     ex_npc;
    logic [5:0]      ex_write_addr;
    riscv::inst_type ex_i;
    logic            ex_mem_ce;
    logic            ex_rw;
    logic            ex_bw;
    logic            ex_wreg;
    logic            mem_stall;
    logic            dmem_ce;
    logic            dmem_rw;
    logic [3:0]      dmem_be;
    logic [31:0]     dmem_addr;
    logic [31:0]     dmem_wdata;
    logic [31:0]     dmem_rdata;
    logic            dmem_ready;
    logic            wb_valid;
    logic [31:0]     wb_ralu;
    logic [31:0]     wb_npc;
    logic [31:0]     wb_read_data;
    logic [5:0]      wb_write_addr;
    logic            wb_wreg;
    riscv::inst_type wb_i;
    logic            misalign;
    logic            bus_error;

    int errors = 0;
    int checks = 0;

    mem_stage #(.READY_TIMEOUT(4)) dut (
        .clock(clock), .reset(reset),
        .ex_valid(ex_valid), .ex_ralu(ex_ralu), .ex_rs2(ex_rs2), .ex_npc(ex_npc),
        .ex_write_addr(ex_write_addr), .ex_i(ex_i), .ex_mem_ce(ex_mem_ce),
        .ex_rw(ex_rw), .ex_bw(ex_bw), .ex_wreg(ex_wreg),
        .mem_stall(mem_stall),
        .dmem_ce(dmem_ce), .dmem_rw(dmem_rw), .dmem_be(dmem_be),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
        .wb_valid(wb_valid), .wb_ralu(wb_ralu), .wb_npc(wb_npc),
        .wb_read_data(wb_read_data), .wb_write_addr(wb_write_addr),
        .wb_wreg(wb_wreg), .wb_i(wb_i),
        .misalign(misalign), .bus_error(bus_error)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input riscv::inst_type i, input logic [31:0] addr,
                         input logic [31:0] rs2, input logic ce, input logic rw,
                         input logic wreg, input logic [5:0] wa);
        ex_valid      = 1'b1;
        ex_i          = i;
        ex_ralu       = addr;
        ex_rs2        = rs2;
        ex_npc        = addr + 32'd4;
        ex_mem_ce     = ce;
        ex_rw         = rw;
        ex_wreg       = wreg;
        ex_write_addr = wa;
        ex_bw         = 1'b0;
    endtask

    // Full load/store transaction: accept, `delay` not-ready cycles, completion.
    task automatic do_mem(input string nm, input riscv::inst_type i, input logic [31:0] addr,
                          input logic [31:0] rs2, input logic rw, input int delay,
                          input logic [31:0] rdata, input logic [3:0] exp_be,
                          input logic chk_wd, input logic [31:0] exp_wd,
                          input logic [31:0] exp_rd, input logic exp_wreg);
        drive(i, addr, rs2, 1'b1, rw, 1'b1, 6'd9);
        dmem_ready = 1'b0;
        dmem_rdata = 32'hDEAD_BEEF;
        #1;
        chk({nm, "_stall_accept"}, 32'(mem_stall), 32'd1);
        chk({nm, "_ce_idle"}, 32'(dmem_ce), 32'd0);
        step();
        chk({nm, "_ce"}, 32'(dmem_ce), 32'd1);
        chk({nm, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
        chk({nm, "_be"}, 32'(dmem_be), 32'(exp_be));
        chk({nm, "_rw"}, 32'(dmem_rw), 32'(rw));
        if (chk_wd) chk({nm, "_wdata"}, dmem_wdata, exp_wd);
        for (int k = 0; k < delay; k++) begin
            #1;
            chk({nm, "_stall_wait"}, 32'(mem_stall), 32'd1);
            step();
        end
        dmem_ready = 1'b1;
        dmem_rdata = rdata;
        #1;
        chk({nm, "_stall_ready"}, 32'(mem_stall), 32'd0);
        step();
        chk({nm, "_wb_valid"}, 32'(wb_valid), 32'd1);
        chk({nm, "_rdata"}, wb_read_data, exp_rd);
        chk({nm, "_wreg"}, 32'(wb_wreg), 32'(exp_wreg));
        chk({nm, "_wb_ralu"}, wb_ralu, addr);
        chk({nm, "_wb_i"}, 32'(wb_i), 32'(i));
        chk({nm, "_no_reaccept"}, 32'(dmem_ce), 32'd0);
        dmem_ready = 1'b0;
        ex_valid   = 1'b0;
        step();
        chk({nm, "_wb_valid_drop"}, 32'(wb_valid), 32'd0);
        chk({nm, "_ce_after"}, 32'(dmem_ce), 32'd0);
    endtask

    typedef struct {
        string           nm;
        riscv::inst_type i;
        logic [31:0]     addr;
        logic [5:0]      wa;
        logic            wreg;
        logic            ce;
        logic            rw;
        logic            exp_wreg;
        logic            exp_mis;
    } vec_t;

    vec_t vecs[6];
    int   n;

    initial begin
        vecs[0] = '{"add",    riscv::I_ADD, 32'h0000_1234, 6'd5,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{"sub_nw", riscv::I_SUB, 32'hDEAD_BEEF, 6'd31, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{"lw_mis", riscv::I_LW,  32'h0000_0301, 6'd7,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{"lh_mis", riscv::I_LH,  32'h0000_0105, 6'd8,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{"sw_mis", riscv::I_SW,  32'h0000_0402, 6'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{"sh_mis", riscv::I_SH,  32'h0000_0007, 6'd3,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

        reset      = 1'b1;
        ex_valid   = 1'b0;
        drive(riscv::I_NOP, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 6'd0);
        ex_valid   = 1'b0;
        dmem_ready = 1'b0;
        dmem_rdata = 32'd0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_ralu", wb_ralu, 32'd0);
        chk("rst_wb_rdata", wb_read_data, 32'd0);
        chk("rst_dmem_ce", 32'(dmem_ce), 32'd0);
        chk("rst_dmem_addr", dmem_addr, 32'd0);
        chk("rst_dmem_be", 32'(dmem_be), 32'd0);
        chk("rst_dmem_wdata", dmem_wdata, 32'd0);
        chk("rst_stall", 32'(mem_stall), 32'd0);
        chk("rst_errs", {30'd0, misalign, bus_error}, 32'd0);
        reset = 1'b0;
        step();

        for (int v = 0; v < 6; v++) begin
            drive(vecs[v].i, vecs[v].addr, 32'h5555_AAAA, vecs[v].ce, vecs[v].rw,
                  vecs[v].wreg, vecs[v].wa);
            #1;
            chk({vecs[v].nm, "_stall"}, 32'(mem_stall), 32'd0);
            chk({vecs[v].nm, "_ce"}, 32'(dmem_ce), 32'd0);
            step();
            chk({vecs[v].nm, "_valid"}, 32'(wb_valid), 32'd1);
            chk({vecs[v].nm, "_ralu"}, wb_ralu, vecs[v].addr);
            chk({vecs[v].nm, "_npc"}, wb_npc, vecs[v].addr + 32'd4);
            chk({vecs[v].nm, "_waddr"}, 32'(wb_write_addr), 32'(vecs[v].wa));
            chk({vecs[v].nm, "_wreg"}, 32'(wb_wreg), 32'(vecs[v].exp_wreg));
            chk({vecs[v].nm, "_rdata"}, wb_read_data, 32'd0);
            chk({vecs[v].nm, "_misalign"}, 32'(misalign), 32'(vecs[v].exp_mis));
            chk({vecs[v].nm, "_ce_after"}, 32'(dmem_ce), 32'd0);
            ex_valid = 1'b0;
            step();
            chk({vecs[v].nm, "_valid_drop"}, 32'(wb_valid), 32'd0);
            chk({vecs[v].nm, "_mis_pulse"}, 32'(misalign), 32'd0);
            chk({vecs[v].nm, "_ralu_hold"}, wb_ralu, vecs[v].addr);
        end

        // Aligned LW right after the misaligned ones.
        do_mem("lw", riscv::I_LW, 32'h0000_0300, 32'd0, 1'b1, 0, 32'h1234_5678,
               4'b1111, 1'b0, 32'd0, 32'h1234_5678, 1'b1);
        do_mem("lb", riscv::I_LB, 32'h0000_0103, 32'd0, 1'b1, 3, 32'h80FF_FF00,
               4'b1111, 1'b0, 32'd0, 32'hFFFF_FF80, 1'b1);
        do_mem("lbu", riscv::I_LBU, 32'h0000_0103, 32'd0, 1'b1, 0, 32'h80FF_FF00,
               4'b1111, 1'b0, 32'd0, 32'h0000_0080, 1'b1);
        do_mem("lh", riscv::I_LH, 32'h0000_0102, 32'd0, 1'b1, 1, 32'h8001_7FFF,
               4'b1111, 1'b0, 32'd0, 32'hFFFF_8001, 1'b1);
        do_mem("lhu", riscv::I_LHU, 32'h0000_0100, 32'd0, 1'b1, 0, 32'h8001_F00F,
               4'b1111, 1'b0, 32'd0, 32'h0000_F00F, 1'b1);
        do_mem("sh", riscv::I_SH, 32'h0000_0202, 32'hABCD_1234, 1'b0, 1, 32'hFFFF_FFFF,
               4'b1100, 1'b1, 32'h1234_1234, 32'd0, 1'b0);
        do_mem("sb", riscv::I_SB, 32'h0000_0201, 32'h9876_545A, 1'b0, 2, 32'hFFFF_FFFF,
               4'b0010, 1'b1, 32'h5A5A_5A5A, 32'd0, 1'b0);
        do_mem("sw", riscv::I_SW, 32'h0000_0404, 32'hCAFE_F00D, 1'b0, 0, 32'hFFFF_FFFF,
               4'b1111, 1'b1, 32'hCAFE_F00D, 32'd0, 1'b0);

        // Ready while idle must not produce anything.
        dmem_ready = 1'b1;
        step();
        chk("idle_ready_valid", 32'(wb_valid), 32'd0);
        chk("idle_ready_ce", 32'(dmem_ce), 32'd0);
        chk("idle_ready_err", 32'(bus_error), 32'd0);
        dmem_ready = 1'b0;

        // Timeout with READY_TIMEOUT=4.
        drive(riscv::I_SW, 32'h0000_0600, 32'h1122_3344, 1'b1, 1'b0, 1'b1, 6'd2);
        step();
        n = 0;
        while (dmem_ce && n < 20) begin
            chk("to_no_err_yet", 32'(bus_error), 32'd0);
            n++;
            step();
        end
        chk("to_cycles", 32'(n), 32'd4);
        chk("to_bus_error", 32'(bus_error), 32'd1);
        chk("to_wb_valid", 32'(wb_valid), 32'd1);
        chk("to_wb_wreg", 32'(wb_wreg), 32'd0);
        ex_valid = 1'b0;
        step();
        chk("to_err_pulse", 32'(bus_error), 32'd0);
        chk("to_idle", 32'(dmem_ce), 32'd0);

        // Reset on the second ACCESS cycle of a load.
        drive(riscv::I_LW, 32'h0000_0500, 32'd0, 1'b1, 1'b1, 1'b1, 6'd4);
        step();
        step();
        chk("rst_acc_ce_before", 32'(dmem_ce), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_acc_ce_now", 32'(dmem_ce), 32'd0);
        chk("rst_acc_stall", 32'(mem_stall), 32'd0);
        step();
        chk("rst_acc_valid", 32'(wb_valid), 32'd0);
        chk("rst_acc_err", 32'(bus_error), 32'd0);
        reset    = 1'b0;
        ex_valid = 1'b0;
        step();
        chk("rst_rel_ce", 32'(dmem_ce), 32'd0);
        chk("rst_rel_valid", 32'(wb_valid), 32'd0);
        do_mem("lw_post_rst", riscv::I_LW, 32'h0000_0700, 32'd0, 1'b1, 1, 32'hA5A5_0F0F,
               4'b1111, 1'b0, 32'd0, 32'hA5A5_0F0F, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
